// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte push handshake between a producer (master) and the UART transmitter (slave).
interface uart_transmitter_if;
   import uart_pkg::*;

   logic [UART_DATA_BITS-1:0] tx_data;
   logic                      tx_valid;
   logic                      tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Power-of-two byte FIFO with occupancy count; the head entry is readable combinationally.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic                      pop,
   input  logic [UART_DATA_BITS-1:0] din,
   output logic [UART_DATA_BITS-1:0] dout,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [UART_DATA_BITS-1:0] mem [DEPTH];
   logic [AW-1:0]             wr_ptr;
   logic [AW-1:0]             rd_ptr;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + (AW+1)'(1);
         else if (pop && !push) count <= count - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == FULL_COUNT);
   assign empty = (count == '0);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit path: FIFO-buffered bytes serialised LSB-first with start/stop framing.
// Define UART_TX_PARITY_EN to insert an even parity bit between the data and stop bits.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4,
   parameter int STOP_BITS    = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   uart_transmitter_if.slave           bus,
   output logic                        tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       LAST_DATA_BIT = 3'(UART_DATA_BITS - 1);
   localparam logic             STOP_LAST     = 1'(STOP_BITS - 1);

   tx_state_e                 state, state_next;
   logic [CNT_W-1:0]          baud_cnt, baud_cnt_next;
   logic [2:0]                bit_idx, bit_idx_next;
   logic                      stop_idx, stop_idx_next;
   logic [UART_DATA_BITS-1:0] shift_reg, shift_reg_next;
   logic                      tx_next;
   logic                      bit_done;
   logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [UART_DATA_BITS-1:0] fifo_head;
`ifdef UART_TX_PARITY_EN
   logic                      par_bit, par_bit_next;
`endif

   assign fifo_push    = bus.tx_valid && bus.tx_ready;
   assign bus.tx_ready = !fifo_full;
   assign busy         = (state != IDLE) || (fifo_count != '0);
   assign bit_done     = (baud_cnt == CNT_LAST);

   uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (bus.tx_data),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // tx is registered from tx_next, so the line lags the FSM state by one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         stop_idx  <= 1'b0;
         shift_reg <= '0;
         tx        <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_bit   <= 1'b0;
`endif
      end else begin
         state     <= state_next;
         baud_cnt  <= baud_cnt_next;
         bit_idx   <= bit_idx_next;
         stop_idx  <= stop_idx_next;
         shift_reg <= shift_reg_next;
         tx        <= tx_next;
`ifdef UART_TX_PARITY_EN
         par_bit   <= par_bit_next;
`endif
      end
   end

   always_comb begin
      state_next     = state;
      baud_cnt_next  = bit_done ? '0 : baud_cnt + CNT_W'(1);
      bit_idx_next   = bit_idx;
      stop_idx_next  = stop_idx;
      shift_reg_next = shift_reg;
      fifo_pop       = 1'b0;
      tx_next        = 1'b1;
`ifdef UART_TX_PARITY_EN
      par_bit_next   = par_bit;
`endif

      case (state)
         IDLE: begin
            baud_cnt_next = '0;
            if (!fifo_empty) begin
               fifo_pop       = 1'b1;
               shift_reg_next = fifo_head;
               state_next     = START;
`ifdef UART_TX_PARITY_EN
               par_bit_next   = even_parity(fifo_head);
`endif
            end
         end
         START: begin
            tx_next = 1'b0;
            if (bit_done) begin
               state_next   = DATA;
               bit_idx_next = '0;
            end
         end
         DATA: begin
            tx_next = shift_reg[0];
            if (bit_done) begin
               shift_reg_next = shift_reg >> 1;
               bit_idx_next   = bit_idx + 3'd1;
               stop_idx_next  = 1'b0;
               if (bit_idx == LAST_DATA_BIT) begin
`ifdef UART_TX_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            tx_next = par_bit;
            if (bit_done) begin
               state_next    = STOP;
               stop_idx_next = 1'b0;
            end
         end
`endif
         STOP: begin
            tx_next = 1'b1;
            if (bit_done) begin
               if (stop_idx != STOP_LAST) begin
                  stop_idx_next = stop_idx + 1'b1;
               end else if (!fifo_empty) begin
                  // Chain straight into the next frame with no idle gap.
                  fifo_pop       = 1'b1;
                  shift_reg_next = fifo_head;
                  state_next     = START;
`ifdef UART_TX_PARITY_EN
                  par_bit_next   = even_parity(fifo_head);
`endif
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: vector table, corner sequences and a line-decoding reference monitor.
module tb_uart_transmitter;
   import uart_pkg::*;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int PBITS = 1;
`else
   localparam int PBITS = 0;
`endif
   localparam int FRAME_BITS  = 1 + UART_DATA_BITS + PBITS + 1;
   localparam int FRAME_CYC   = FRAME_BITS * CPB;
   localparam int FRAME2_BITS = FRAME_BITS + 1;

   typedef struct {
      logic [7:0] data;
      logic [8:0] head;
      logic       par;
   } vec_t;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   tx, busy, tx2, busy2;
   logic [$clog2(DEPTH):0] fifo_count, fifo_count2;
   int                     total = 0;
   int                     bad = 0;
   int                     cyc = 0;
   logic [7:0]             exp_q[$];
   int                     start_q[$];
   int                     frames_seen = 0;
   bit                     mon_act = 1'b0;

   uart_transmitter_if bus ();
   uart_transmitter_if bus2 ();

   uart_transmitter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut (
      .clk(clk), .rst(rst), .bus(bus), .tx(tx), .busy(busy), .fifo_count(fifo_count)
   );

   uart_transmitter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2), .tx(tx2), .busy(busy2), .fifo_count(fifo_count2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Called on a negedge; returns on the negedge after the accepting posedge.
   task automatic applyStimulus(input logic [7:0] data, output int waited);
      waited = 0;
      exp_q.push_back(data);
      bus.tx_data  = data;
      bus.tx_valid = 1'b1;
      while (!bus.tx_ready && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("push_ready", 32'(bus.tx_ready), 32'd1);
      @(negedge clk);
      bus.tx_valid = 1'b0;
   endtask

   task automatic waitIdle(input int budget);
      int n = 0;
      while ((busy || mon_act || exp_q.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      checkOutput("drain_queue", 32'(exp_q.size()), 32'd0);
      checkOutput("drain_busy", 32'(busy), 32'd0);
      checkOutput("drain_tx", 32'(tx), 32'd1);
   endtask

   // Reference receiver: samples mid-bit and compares each decoded byte with the push order.
   initial begin : monitor
      int t;
      logic [FRAME_BITS-1:0] bits;
      logic [7:0] got;
      t = 0;
      bits = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            mon_act = 1'b0;
         end else begin
            if (!mon_act && tx == 1'b0) begin
               mon_act = 1'b1;
               t = 0;
               start_q.push_back(cyc);
            end
            if (mon_act) begin
               if (t % CPB == CPB / 2) bits[t / CPB] = tx;
               if (t == (FRAME_BITS - 1) * CPB + CPB / 2) begin
                  mon_act = 1'b0;
                  frames_seen++;
                  got = bits[8:1];
                  checkOutput("mon_start", 32'(bits[0]), 32'd0);
                  checkOutput("mon_stop", 32'(bits[FRAME_BITS-1]), 32'd1);
`ifdef UART_TX_PARITY_EN
                  checkOutput("mon_parity", 32'(bits[9]), 32'(^got));
`endif
                  if (exp_q.size() == 0) begin
                     total++;
                     bad++;
                     $display("[TB] FAIL mon_extra_frame: got byte 0x%0h, want no frame (cycle %0d)", got, cyc);
                  end else begin
                     checkOutput("mon_byte", 32'(got), 32'(exp_q.pop_front()));
                  end
               end
               t++;
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL global_timeout: got no finish, want finish before time limit");
      $fatal(1, "[TB] timeout");
   end

   initial begin : main
      vec_t vecs[5];
      logic [7:0] seq3[4];
      int waited, peak, lows, frames_before, n;
      logic expbit;

      vecs[0] = '{8'h55, 9'b010101010, 1'b0};
      vecs[1] = '{8'h07, 9'b000001110, 1'b1};
      vecs[2] = '{8'h03, 9'b000000110, 1'b0};
      vecs[3] = '{8'h80, 9'b100000000, 1'b1};
      vecs[4] = '{8'hA3, 9'b101000110, 1'b0};
      seq3[0] = 8'hA3; seq3[1] = 8'h0F; seq3[2] = 8'hFF; seq3[3] = 8'h00;

      bus.tx_valid  = 1'b0;
      bus.tx_data   = 8'h00;
      bus2.tx_valid = 1'b0;
      bus2.tx_data  = 8'h00;
      rst = 1'b1;
      #2 rst = 1'b0;

      $display("[TB] reset idle");
      repeat (3) begin
         @(negedge clk);
         checkOutput("reset_hold", 32'({tx, bus.tx_ready, busy, fifo_count}), 32'b110000);
      end
      rst = 1'b1;
      repeat (20) begin
         @(negedge clk);
         checkOutput("reset_idle", 32'({tx, bus.tx_ready, busy, fifo_count}), 32'b110000);
      end

      $display("[TB] single-byte vector table");
      for (int v = 0; v < 5; v++) begin
         applyStimulus(vecs[v].data, waited);
         checkOutput("latency_1", 32'(tx), 32'd1);
         @(negedge clk);
         checkOutput("latency_2", 32'(tx), 32'd1);
         for (int k = 0; k < FRAME_BITS; k++) begin
            if (k < 9) expbit = vecs[v].head[k];
            else if (PBITS == 1 && k == 9) expbit = vecs[v].par;
            else expbit = 1'b1;
            for (int c = 0; c < CPB; c++) begin
               @(negedge clk);
               checkOutput("frame_bit", 32'(tx), 32'(expbit));
            end
         end
         @(negedge clk);
         checkOutput("post_frame", 32'({tx, busy, fifo_count}), 32'b10000);
         waitIdle(200);
      end

      $display("[TB] back-to-back frames");
      start_q.delete();
      peak = 0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(seq3[i], waited);
         if (int'(fifo_count) > peak) peak = int'(fifo_count);
      end
      checkOutput("b2b_peak", 32'(peak), 32'd3);
      waitIdle(4 * FRAME_CYC + 50);
      checkOutput("b2b_frames", 32'(start_q.size()), 32'd4);
      for (int i = 1; i < start_q.size(); i++)
         checkOutput("b2b_gap", 32'(start_q[i] - start_q[i-1]), 32'(FRAME_CYC));

      $display("[TB] full backpressure");
      for (int i = 0; i < 6; i++) begin
         applyStimulus(8'($urandom), waited);
         if (i == 4) begin
            checkOutput("full_count", 32'(fifo_count), 32'(DEPTH));
            checkOutput("full_ready", 32'(bus.tx_ready), 32'd0);
         end
         if (i == 5) checkOutput("full_wait", 32'(waited), 32'(FRAME_CYC - 3));
      end
      waitIdle(6 * FRAME_CYC + 50);

      $display("[TB] reset mid-frame");
      applyStimulus(8'hC6, waited);
      applyStimulus(8'($urandom), waited);
      applyStimulus(8'($urandom), waited);
      checkOutput("mid_count", 32'(fifo_count), 32'd2);
      repeat (17) @(negedge clk);
      #1;
      checkOutput("mid_bit3", 32'(tx), 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("mid_async", 32'({tx, bus.tx_ready, busy, fifo_count}), 32'b110000);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      frames_before = frames_seen;
      lows = 0;
      repeat (100) begin
         @(negedge clk);
         if (!tx) lows++;
      end
      checkOutput("post_reset_low", 32'(lows), 32'd0);
      checkOutput("post_reset_frames", 32'(frames_seen - frames_before), 32'd0);
      checkOutput("post_reset_state", 32'({tx, bus.tx_ready, busy, fifo_count}), 32'b110000);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 24; i++) begin
         applyStimulus(8'($urandom), waited);
         repeat ($urandom_range(0, 60)) @(negedge clk);
      end
      waitIdle(24 * FRAME_CYC + 200);

      $display("[TB] two stop bits");
      checkOutput("stop2_ready", 32'(bus2.tx_ready), 32'd1);
      bus2.tx_data  = 8'h03;
      bus2.tx_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus2.tx_valid = 1'b0;
      checkOutput("stop2_latency", 32'(tx2), 32'd1);
      for (int k = 0; k < FRAME2_BITS; k++) begin
         if (k < 9) expbit = vecs[2].head[k];
         else if (PBITS == 1 && k == 9) expbit = vecs[2].par;
         else expbit = 1'b1;
         for (int c = 0; c < CPB; c++) begin
            @(negedge clk);
            checkOutput("stop2_bit", 32'(tx2), 32'(expbit));
         end
      end
      @(negedge clk);
      checkOutput("stop2_next_start", 32'(tx2), 32'd0);
      n = 0;
      while (busy2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      checkOutput("stop2_drain", 32'({tx2, busy2, fifo_count2}), 32'b10000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
